alu_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 33 +++
 rtl/alu_seq_comb.sv | 51 +++++
 rtl/alu_seq.sv | 208 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU.
// Holds the 4-bit operation codes, the flag bit positions inside the
// {carry, overflow, zero, negative} vector and the control FSM state type.
package alu_seq_pkg;

    // Operation codes (4 bits). Codes 13..15 are undefined.
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_ADC = 4'h2;
    localparam logic [3:0] OP_SBC = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_CMP = 4'h7;
    localparam logic [3:0] OP_MOV = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_ASR = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;

    // Bit positions inside the flags vector.
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_comb.sv
// Combinational add/sub/logic core of the sequential ALU.
// Ports:
//   op       in  4        operation code
//   a, b     in  WIDTH    operands
//   cin      in  1        carry/borrow input for ADC/SBC
//   sum      out WIDTH+1  {carry, result}; for subtraction carry means borrow
//   overflow out 1        signed overflow of the add/sub
// Shift, multiply and undefined codes produce zero here; the top handles them.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   sum,
    output logic             overflow
);

    logic [WIDTH:0] a_x;
    logic [WIDTH:0] b_x;
    logic [WIDTH:0] c_x;

    assign a_x = {1'b0, a};
    assign b_x = {1'b0, b};
    assign c_x = {{WIDTH{1'b0}}, cin};

    always_comb begin
        sum      = '0;
        overflow = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                sum      = (op == OP_ADC) ? (a_x + b_x + c_x) : (a_x + b_x);
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                // Zero-extended subtraction leaves the borrow in bit WIDTH.
                sum      = (op == OP_SBC) ? (a_x - b_x - c_x) : (a_x - b_x);
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  sum = {1'b0, a & b};
            OP_OR:   sum = {1'b0, a | b};
            OP_XOR:  sum = {1'b0, a ^ b};
            OP_MOV:  sum = {1'b0, a};
            default: sum = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with start/busy/done handshake.
// Handshake: start is sampled only while the FSM is idle; an accepted start
// latches operator and operands. Single-cycle ops raise done for the cycle
// after acceptance. Shifts (amount > 0) and MUL hold busy high while they run,
// then raise done for exactly one cycle with busy already low. Starts seen
// while busy are dropped. result/flags stay valid until the next operation.
// Ports:
//   clk, reset_n    clock (rising edge), asynchronous active-low reset
//   start           issue request
//   operator        4-bit operation code
//   value1, value2  operands (value2 low SHW bits = shift amount)
//   busy, done      handshake outputs
//   result          result (low half for MUL)
//   result_hi       MUL high half, zero otherwise
//   flags           {carry, overflow, zero, negative}
//   state_dbg       current FSM state encoding
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       operator,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = SHW + 1;

    state_t             state;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   prod_hi;
    logic [WIDTH-1:0]   prod_lo;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH:0]     core_sum;
    logic               core_ov;
    logic [SHW-1:0]     sh_amt;

    logic [WIDTH-1:0]   sh_next;
    logic               sh_out;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   hi_next;
    logic [WIDTH-1:0]   lo_next;

    assign state_dbg = state;
    assign sh_amt    = value2[SHW-1:0];

    alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .op       (operator),
        .a        (value1),
        .b        (value2),
        .cin      (flags[FLAG_C]),
        .sum      (core_sum),
        .overflow (core_ov)
    );

    // One shift step on the working register; sh_out is the bit leaving it.
    always_comb begin
        sh_next = work;
        sh_out  = 1'b0;
        case (op_q)
            OP_SHL: begin
                sh_next = {work[WIDTH-2:0], 1'b0};
                sh_out  = work[WIDTH-1];
            end
            OP_SHR: begin
                sh_next = {1'b0, work[WIDTH-1:1]};
                sh_out  = work[0];
            end
            OP_ASR: begin
                sh_next = {work[WIDTH-1], work[WIDTH-1:1]};
                sh_out  = work[0];
            end
            default: begin
                sh_next = work;
                sh_out  = 1'b0;
            end
        endcase
    end

    // Shift-add multiply step: product register {prod_hi, prod_lo} starts as
    // {0, multiplier}; each step conditionally adds the multiplicand to the
    // high half and shifts the whole register right by one, carry included.
    always_comb begin
        addend  = prod_lo[0] ? mcand : '0;
        mul_sum = {1'b0, prod_hi} + {1'b0, addend};
        hi_next = mul_sum[WIDTH:1];
        lo_next = {mul_sum[0], prod_lo[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            work      <= '0;
            mcand     <= '0;
            prod_hi   <= '0;
            prod_lo   <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= operator;
                        case (operator)
                            OP_ADD, OP_SUB, OP_ADC, OP_SBC,
                            OP_AND, OP_OR, OP_XOR, OP_MOV: begin
                                result    <= core_sum[WIDTH-1:0];
                                result_hi <= '0;
                                flags     <= {core_sum[WIDTH], core_ov,
                                              core_sum[WIDTH-1:0] == '0,
                                              core_sum[WIDTH-1]};
                                done      <= 1'b1;
                            end
                            OP_CMP: begin
                                flags <= {core_sum[WIDTH], core_ov,
                                          core_sum[WIDTH-1:0] == '0,
                                          core_sum[WIDTH-1]};
                                done  <= 1'b1;
                            end
                            OP_SHL, OP_SHR, OP_ASR: begin
                                if (sh_amt == '0) begin
                                    result    <= value1;
                                    result_hi <= '0;
                                    flags     <= {1'b0, 1'b0, value1 == '0,
                                                  value1[WIDTH-1]};
                                    done      <= 1'b1;
                                end else begin
                                    work  <= value1;
                                    cnt   <= {1'b0, sh_amt};
                                    busy  <= 1'b1;
                                    state <= ST_SHIFT;
                                end
                            end
                            OP_MUL: begin
                                mcand   <= value1;
                                prod_hi <= '0;
                                prod_lo <= value2;
                                cnt     <= CNT_W'(WIDTH);
                                busy    <= 1'b1;
                                state   <= ST_MUL;
                            end
                            default: begin
                                result    <= '0;
                                result_hi <= '0;
                                flags     <= 4'b0010;
                                done      <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_SHIFT: begin
                    work <= sh_next;
                    cnt  <= cnt - CNT_W'(1);
                    // The final step writes the result directly, so busy
                    // covers exactly 'amount' cycles.
                    if (cnt == CNT_W'(1)) begin
                        result    <= sh_next;
                        result_hi <= '0;
                        flags     <= {sh_out, 1'b0, sh_next == '0,
                                      sh_next[WIDTH-1]};
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    prod_hi <= hi_next;
                    prod_lo <= lo_next;
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result    <= lo_next;
                        result_hi <= hi_next;
                        flags     <= {|hi_next, 1'b0, lo_next == '0,
                                      lo_next[WIDTH-1]};
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): table of single-cycle vectors
// applied on consecutive cycles, plus hand sequences for shift, multiply,
// start-while-busy and reset-mid-operation.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [3:0]   operator;
    logic [W-1:0] value1;
    logic [W-1:0] value2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic [3:0]   flags;
    logic [1:0]   state_dbg;

    int n_cmp;
    int n_fail;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .operator  (operator),
        .value1    (value1),
        .value2    (value2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] v1;
        logic [W-1:0] v2;
        logic [W-1:0] exp_res;
        logic [3:0]   exp_flags;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one start with the given op; returns after the accepting edge + #1.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        operator = op;
        value1   = a;
        value2   = b;
        @(posedge clk);
        #1;
    endtask

    // Multi-cycle op: counts busy cycles until done, optionally injects a
    // start while busy at cycle 'spur' (negative = none), then checks that
    // no further done appears.
    task automatic run_multi(input string name, input logic [3:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input int exp_busy, input int spur,
                             input logic [W-1:0] exp_res, input logic [W-1:0] exp_hi,
                             input logic [3:0] exp_flags);
        int busy_cnt;
        int guard;
        int extra;
        issue(op, a, b);
        start  = 1'b0;
        value1 = W'($urandom_range(0, 65535));
        value2 = W'($urandom_range(0, 65535));
        busy_cnt = 0;
        guard    = 0;
        while (!done && guard < 200) begin
            if (busy) busy_cnt++;
            if (guard == spur) begin
                start    = 1'b1;
                operator = OP_ADD;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        start = 1'b0;
        check({name, "_done"}, {31'b0, done}, 32'd1);
        check({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        check({name, "_busy_cycles"}, busy_cnt, exp_busy);
        check({name, "_result"}, result, exp_res);
        check({name, "_result_hi"}, result_hi, exp_hi);
        check({name, "_flags"}, flags, exp_flags);
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check({name, "_extra_done"}, extra, 0);
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        operator = '0;
        value1   = '0;
        value2   = '0;

        //          op      v1        v2        result    {C,V,Z,N}
        vecs[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101};
        vecs[1]  = '{OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 4'b1001};
        vecs[2]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010};
        vecs[3]  = '{OP_ADC, 16'h0000, 16'h0000, 16'h0001, 4'b0000};
        vecs[4]  = '{OP_CMP, 16'h1234, 16'h1234, 16'h0001, 4'b0010};
        vecs[5]  = '{OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
        vecs[6]  = '{OP_OR,  16'hF0F0, 16'h0FF0, 16'hFFF0, 4'b0001};
        vecs[7]  = '{OP_XOR, 16'hF0F0, 16'h0FF0, 16'hFF00, 4'b0001};
        vecs[8]  = '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b1001};
        vecs[9]  = '{OP_SBC, 16'h0005, 16'h0003, 16'h0001, 4'b0000};
        vecs[10] = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0100};
        vecs[11] = '{OP_MOV, 16'h8000, 16'h5555, 16'h8000, 4'b0001};
        vecs[12] = '{4'hF,   16'h1234, 16'h5678, 16'h0000, 4'b0010};
        vecs[13] = '{OP_SHL, 16'h1234, 16'h0010, 16'h1234, 4'b0000};
        vecs[14] = '{OP_SHR, 16'hABCD, 16'h0000, 16'hABCD, 4'b0001};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_result_hi", result_hi, 32'd0);
        check("rst_flags", flags, 32'd0);
        check("rst_state", state_dbg, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // single-cycle table, one start per cycle (back-to-back)
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].v1, vecs[i].v2);
            check($sformatf("vec%0d_done", i), {31'b0, done}, 32'd1);
            check($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'd0);
            check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
            check($sformatf("vec%0d_result_hi", i), result_hi, 32'd0);
            check($sformatf("vec%0d_flags", i), flags, vecs[i].exp_flags);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_done_low", {31'b0, done}, 32'd0);
        check("idle_result_held", result, 32'hABCD);

        // multi-cycle sequences
        run_multi("shl3", OP_SHL, 16'h8001, 16'h0003, 3, -1, 16'h0008, 16'h0000, 4'b0000);
        run_multi("asr15", OP_ASR, 16'h8000, 16'h000F, 15, -1, 16'hFFFF, 16'h0000, 4'b0001);
        run_multi("shr1", OP_SHR, 16'h0003, 16'h0001, 1, -1, 16'h0001, 16'h0000, 4'b1000);
        run_multi("mul", OP_MUL, 16'hFFFF, 16'h0002, 16, 4, 16'hFFFE, 16'h0001, 4'b1001);

        // a single-cycle op after MUL clears result_hi
        issue(OP_ADD, 16'h0001, 16'h0001);
        start = 1'b0;
        check("post_mul_add_result", result, 32'h0002);
        check("post_mul_add_hi", result_hi, 32'h0000);
        check("post_mul_add_flags", flags, 32'h0);

        // reset during MUL cycle 5
        issue(OP_MUL, 16'h1234, 16'h5678);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("mul_running_busy", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_flags", flags, 32'd0);
        check("abort_state", state_dbg, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_abort_no_done", {31'b0, done}, 32'd0);
        issue(OP_ADD, 16'h0003, 16'h0004);
        start = 1'b0;
        check("after_abort_add_done", {31'b0, done}, 32'd1);
        check("after_abort_add_result", result, 32'h0007);
        check("after_abort_add_flags", flags, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
